// File: rtl/tx_pkt_ctrl.sv
// Packet sequencer upstream of the tx baseband: loads N_BYTE payload bytes into the
// tx FIFO, waits an inter-packet gap, pulses tx/rx start, then waits for tx completion.
module tx_pkt_ctrl #(
    parameter int N_BYTE   = 8,
    parameter int GAP      = 128,
    parameter int ARM_WAIT = 100,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [7:0]      s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            tx_wr_en,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    output logic            rx_start,
    input  logic            txready,
    output logic            busy,
    output logic            pkt_done,
    output logic [CNTW-1:0] pkt_cnt
);

    localparam int BW = (N_BYTE   > 1) ? $clog2(N_BYTE)   : 1;
    localparam int GW = (GAP      > 1) ? $clog2(GAP)      : 1;
    localparam int AW = (ARM_WAIT > 1) ? $clog2(ARM_WAIT) : 1;

    localparam logic [BW-1:0] BYTE_LAST = BW'(N_BYTE - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
    localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_WAIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_START,
        ST_ARM,
        ST_WAIT_DONE
    } state_t;

    state_t          state, state_n;
    logic [BW-1:0]   byte_cnt, byte_cnt_n;
    logic [GW-1:0]   gap_cnt, gap_cnt_n;
    logic [AW-1:0]   arm_cnt, arm_cnt_n;

    logic            s_ready_n;
    logic            tx_wr_en_n;
    logic [7:0]      tx_data_n;
    logic            tx_start_n;
    logic            busy_n;
    logic            pkt_done_n;
    logic [CNTW-1:0] pkt_cnt_n;
    logic            accept;

    assign accept = en & s_valid & s_ready;

    // All outputs are registered, so next-cycle values are derived here from the next state.
    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        gap_cnt_n  = gap_cnt;
        arm_cnt_n  = arm_cnt;
        tx_start_n = 1'b0;
        pkt_done_n = 1'b0;
        pkt_cnt_n  = pkt_cnt;
        tx_wr_en_n = accept;
        tx_data_n  = accept ? s_data : tx_data;

        if (en) begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (N_BYTE == 1) begin
                            state_n   = ST_GAP;
                            gap_cnt_n = '0;
                        end else begin
                            state_n    = ST_LOAD;
                            byte_cnt_n = BW'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (byte_cnt == BYTE_LAST) begin
                            state_n   = ST_GAP;
                            gap_cnt_n = '0;
                        end else begin
                            byte_cnt_n = byte_cnt + BW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n    = ST_START;
                        tx_start_n = 1'b1;
                    end else begin
                        gap_cnt_n = gap_cnt + GW'(1);
                    end
                end
                ST_START: begin
                    state_n   = ST_ARM;
                    arm_cnt_n = '0;
                end
                ST_ARM: begin
                    if (arm_cnt == ARM_LAST) begin
                        state_n = ST_WAIT_DONE;
                    end else begin
                        arm_cnt_n = arm_cnt + AW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (txready) begin
                        state_n    = ST_IDLE;
                        pkt_done_n = 1'b1;
                        pkt_cnt_n  = pkt_cnt + CNTW'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        // s_ready also drops for the cycle after any disabled edge.
        s_ready_n = en && ((state_n == ST_IDLE) || (state_n == ST_LOAD));
        busy_n    = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            arm_cnt  <= '0;
            s_ready  <= 1'b0;
            tx_wr_en <= 1'b0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            rx_start <= 1'b0;
            busy     <= 1'b0;
            pkt_done <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            state    <= state_n;
            byte_cnt <= byte_cnt_n;
            gap_cnt  <= gap_cnt_n;
            arm_cnt  <= arm_cnt_n;
            s_ready  <= s_ready_n;
            tx_wr_en <= tx_wr_en_n;
            tx_data  <= tx_data_n;
            tx_start <= tx_start_n;
            rx_start <= tx_start_n;
            busy     <= busy_n;
            pkt_done <= pkt_done_n;
            pkt_cnt  <= pkt_cnt_n;
        end
    end

endmodule

// File: tb/tb_tx_pkt_ctrl.sv
// Randomized bench for tx_pkt_ctrl; a timeline model counts enabled edges from the last
// accepted byte to predict every output each cycle.
module tb_tx_pkt_ctrl;

    localparam int N_BYTE   = 8;
    localparam int GAP      = 128;
    localparam int ARM_WAIT = 100;
    localparam int CNTW     = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic [7:0]      s_data = 8'h00;
    logic            s_valid = 1'b0;
    logic            txready = 1'b0;
    logic            s_ready, tx_wr_en, tx_start, rx_start, busy, pkt_done;
    logic [7:0]      tx_data;
    logic [CNTW-1:0] pkt_cnt;

    tx_pkt_ctrl #(.N_BYTE(N_BYTE), .GAP(GAP), .ARM_WAIT(ARM_WAIT), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .tx_wr_en(tx_wr_en), .tx_data(tx_data),
        .tx_start(tx_start), .rx_start(rx_start), .txready(txready),
        .busy(busy), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes loaded so far and the enabled-edge index of the last one.
    int         ecnt, nbytes, a_edge, exp_cnt;
    logic       exp_ready, exp_wr, exp_start, exp_done, exp_busy;
    logic [7:0] exp_data;

    int         cyc = 0;
    int         since_start, gap_ticks;
    int         v_mode, en_mode, tr_mode, rise_at;
    logic [7:0] pkt_bytes [N_BYTE];
    int         n_wr, n_st, n_rx, n_dn, last_wr_cyc, start_cyc, done_cyc;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        ecnt = 0; nbytes = 0; a_edge = 0; exp_cnt = 0;
        exp_ready = 1'b0; exp_wr = 1'b0; exp_start = 1'b0; exp_done = 1'b0;
        exp_busy = 1'b0; exp_data = 8'h00;
        since_start = -1; gap_ticks = 0;
    endtask

    task automatic model_edge();
        exp_wr = 1'b0; exp_start = 1'b0; exp_done = 1'b0;
        if (en) begin
            ecnt++;
            if (nbytes < N_BYTE) begin
                if (s_valid && exp_ready) begin
                    exp_wr   = 1'b1;
                    exp_data = s_data;
                    nbytes++;
                    if (nbytes == N_BYTE) a_edge = ecnt;
                end
            end else begin
                if (ecnt == a_edge + GAP) exp_start = 1'b1;
                if (ecnt >= a_edge + GAP + ARM_WAIT + 2 && txready) begin
                    exp_done = 1'b1;
                    nbytes   = 0;
                    exp_cnt  = (exp_cnt + 1) % (1 << CNTW);
                end
            end
            exp_ready = (nbytes < N_BYTE);
        end else begin
            exp_ready = 1'b0;
        end
        exp_busy = (nbytes > 0);
        if (exp_start) since_start = 0;
        else if (since_start >= 0) since_start++;
        if (nbytes == N_BYTE && since_start < 0) gap_ticks++;
        if (exp_done) begin
            since_start = -1;
            gap_ticks   = 0;
        end
    endtask

    task automatic compare_all();
        checkOutput("s_ready",  32'(s_ready),  32'(exp_ready));
        checkOutput("tx_wr_en", 32'(tx_wr_en), 32'(exp_wr));
        checkOutput("tx_data",  32'(tx_data),  32'(exp_data));
        checkOutput("tx_start", 32'(tx_start), 32'(exp_start));
        checkOutput("rx_start", 32'(rx_start), 32'(exp_start));
        checkOutput("pkt_done", 32'(pkt_done), 32'(exp_done));
        checkOutput("busy",     32'(busy),     32'(exp_busy));
        checkOutput("pkt_cnt",  32'(pkt_cnt),  32'(exp_cnt));
        if (tx_wr_en) begin n_wr++; last_wr_cyc = cyc; end
        if (tx_start) begin n_st++; start_cyc = cyc; end
        if (rx_start) n_rx++;
        if (pkt_done) begin n_dn++; done_cyc = cyc; end
    endtask

    task automatic drive_inputs();
        case (en_mode)
            0:       en = 1'b1;
            1:       en = !((gap_ticks >= 10 && gap_ticks < 30) || (since_start >= 10 && since_start < 30));
            default: en = ($urandom % 8) != 0;
        endcase
        case (v_mode)
            0:       s_valid = 1'b1;
            1:       s_valid = cyc[0];
            default: s_valid = 1'($urandom % 2);
        endcase
        s_data = (nbytes < N_BYTE) ? pkt_bytes[nbytes] : 8'($urandom);
        if (tr_mode == 1)
            txready = (since_start < 50) ? 1'b1 : (since_start >= 550);
        else
            txready = (since_start >= 0 && since_start >= rise_at) ? 1'b1 : 1'($urandom % 2);
    endtask

    task automatic step_cycle();
        @(posedge clk);
        cyc++;
        if (rst) model_edge();
        #1;
        compare_all();
        drive_inputs();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) step_cycle();
        rst = 1'b1;
    endtask

    task automatic set_packet(input int vm, input int em, input int tm, input int ra, input logic random_bytes);
        v_mode = vm; en_mode = em; tr_mode = tm; rise_at = ra;
        for (int i = 0; i < N_BYTE; i++)
            pkt_bytes[i] = random_bytes ? 8'($urandom) : ((i == 0) ? 8'h22 : 8'(i));
        n_wr = 0; n_st = 0; n_rx = 0; n_dn = 0;
        last_wr_cyc = 0; start_cyc = 0; done_cyc = 0;
        drive_inputs();
    endtask

    task automatic applyStimulus(input int vm, input int em, input int tm, input int ra,
                                 input logic random_bytes, input int exp_delay);
        int guard;
        set_packet(vm, em, tm, ra, random_bytes);
        guard = 0;
        while (n_dn == 0 && guard < 3000) begin
            step_cycle();
            guard++;
        end
        checkOutput("pkt_timeout", 32'(guard < 3000), 32'd1);
        checkOutput("n_writes",    32'(n_wr), 32'(N_BYTE));
        checkOutput("n_tx_start",  32'(n_st), 32'd1);
        checkOutput("n_rx_start",  32'(n_rx), 32'd1);
        checkOutput("n_pkt_done",  32'(n_dn), 32'd1);
        checkOutput("arm_hold",    32'((done_cyc - start_cyc) >= ARM_WAIT + 2), 32'd1);
        if (exp_delay >= 0)
            checkOutput("start_delay", 32'(start_cyc - last_wr_cyc), 32'(exp_delay));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        v_mode = 0; en_mode = 0; tr_mode = 0; rise_at = ARM_WAIT;
        for (int i = 0; i < N_BYTE; i++) pkt_bytes[i] = 8'h00;
        model_reset();
        do_reset();

        // Back-to-back load, then toggling valid, then txready held high before the arm window.
        applyStimulus(0, 0, 0, ARM_WAIT + 5, 1'b0, GAP);
        applyStimulus(1, 0, 0, ARM_WAIT + 3, 1'b0, GAP);
        applyStimulus(0, 0, 1, 0, 1'b1, GAP);
        checkOutput("cnt_after_3", 32'(pkt_cnt), 32'd3);
        // en dropped for 20 cycles in the gap and again while armed.
        applyStimulus(0, 1, 0, ARM_WAIT + 30, 1'b1, GAP + 20);

        // Reset in the middle of loading.
        set_packet(0, 0, 0, ARM_WAIT, 1'b1);
        guard = 0;
        while (nbytes < 4 && guard < 100) begin
            step_cycle();
            guard++;
        end
        checkOutput("mid_load_reached", 32'(nbytes), 32'd4);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checkOutput("async_s_ready",  32'(s_ready),  32'd0);
        checkOutput("async_tx_wr_en", 32'(tx_wr_en), 32'd0);
        checkOutput("async_tx_data",  32'(tx_data),  32'd0);
        checkOutput("async_busy",     32'(busy),     32'd0);
        checkOutput("async_pkt_cnt",  32'(pkt_cnt),  32'd0);
        repeat (2) step_cycle();
        rst = 1'b1;
        applyStimulus(2, 0, 0, ARM_WAIT, 1'b1, GAP);
        checkOutput("cnt_after_reset_pkt", 32'(pkt_cnt), 32'd1);

        // Four random packets from a fresh reset exercise the counter wrap.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            applyStimulus(2, 2, 0, ARM_WAIT + int'($urandom % 20), 1'b1, -1);
            checkOutput("pkt_cnt_seq", 32'(pkt_cnt), 32'((p + 1) % 4));
        end

        repeat (5) step_cycle();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_pkt_ctrl.md
Name: tx_pkt_ctrl

Overview:
Packet sequencer that sits directly upstream of the tx baseband block. It accepts payload bytes over a valid/ready stream and writes exactly N_BYTE of them into the tx FIFO. It enforces an inter-packet gap, issues the single-cycle txstart and its companion rxstart pulse, then waits for tx to report completion through txready. It replaces the hand-written write/gap/start/wait sequencing with synthesizable RTL for the SoC.

Parameters:
N_BYTE, 8, payload bytes per packet written to tx FIFO (>=1)
GAP, 128, clk cycles from end of FIFO load to txstart (>=1)
ARM_WAIT, 100, clk cycles after txstart before txready is sampled (>=1)
CNTW, 16, width of packet-sent counter

Ports:
clk  input  1  system clock (32 MHz)
rst  input  1  asynchronous active-low reset
en  input  1  clock enable; 0 freezes all state, counters and outputs except strobes
s_data  input  8  payload byte
s_valid  input  1  payload byte valid
s_ready  output  1  block accepts byte this cycle
tx_wr_en  output  1  tx FIFO write strobe
tx_data  output  8  tx FIFO write data
tx_start  output  1  one-cycle start pulse to tx
rx_start  output  1  one-cycle start pulse to rx/demod, coincident with tx_start
txready  input  1  tx idle/done flag
busy  output  1  high in any state other than IDLE
pkt_done  output  1  one-cycle pulse when a packet completes
pkt_cnt  output  CNTW  packets completed since reset, wraps

Behaviour:
- Reset (rst=0, async): state=IDLE; s_ready=0, tx_wr_en=0, tx_data=0, tx_start=0, rx_start=0, busy=0, pkt_done=0, pkt_cnt=0; internal counters=0.
- All outputs registered. A byte accepted at edge k (s_valid&s_ready&en) gives tx_wr_en=1 and tx_data=s_data during cycle k+1.
- en=0: state and counters hold. s_ready, tx_wr_en, tx_start, rx_start and pkt_done are 0. busy and pkt_cnt hold.
- IDLE: s_ready=1. The first accepted byte moves the FSM to LOAD with byte_cnt=1.
  - If N_BYTE=1, the FSM goes directly to GAP.
- LOAD: s_ready=1. Each accepted byte increments byte_cnt.
  - On the acceptance that makes byte_cnt==N_BYTE: s_ready drops in the next cycle and the FSM goes to GAP with gap_cnt=0.
  - s_valid gaps stall LOAD indefinitely; no bytes are dropped or duplicated.
- GAP: s_ready=0. gap_cnt increments each enabled cycle. At gap_cnt==GAP-1 the FSM goes to START.
- START: one cycle. tx_start=1 and rx_start=1 in the same cycle. Next state ARM with arm_cnt=0.
- ARM: txready is ignored. At arm_cnt==ARM_WAIT-1 the FSM goes to WAIT_DONE.
- WAIT_DONE: when txready=1, pkt_done=1 for one cycle, pkt_cnt increments, and the FSM returns to IDLE.
  - No timeout.
- Timing, with en held high and bytes presented back-to-back:
  - last byte accepted at edge L;
  - tx_start high in cycle L+GAP+1;
  - txready sampled no earlier than L+GAP+1+ARM_WAIT.
- pkt_cnt wraps from 2^CNTW-1 to 0.
- Simultaneous events:
  - a byte offered while not in IDLE/LOAD is not accepted (s_ready=0);
  - txready=1 during GAP/START/ARM has no effect.
- Reset asserted mid-packet aborts immediately to IDLE. Partial FIFO contents are not flushed by this block; the integrator resets tx alongside.

Test Plan:
1. Reset, then 8 back-to-back bytes 0x22,0x01..0x07 -> tx_wr_en high 8 consecutive cycles with matching tx_data; tx_start/rx_start pulse exactly once, 129 cycles after the last acceptance; busy=1 throughout.
2. Same as scenario 1 with s_valid toggling 1/0 -> exactly 8 writes with the byte order preserved; gap count starts at the 8th acceptance; a 9th byte is not accepted (s_ready=0).
3. Hold txready=1 from time 0 -> no pkt_done before ARM_WAIT=100 cycles after tx_start. Then drop txready for 500 cycles and raise it -> one pkt_done, pkt_cnt=1.
4. Drop en for 20 cycles during GAP and ARM -> tx_start delayed by exactly 20 cycles; no strobes while en=0.
5. Assert rst low mid-LOAD (after 4 bytes) -> all outputs 0 asynchronously. Next packet after release writes 8 fresh bytes; pkt_cnt=0.
6. Run 4 packets with CNTW=2 -> pkt_cnt sequence 1,2,3,0; 4 pkt_done pulses.
